// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: states, opcode/op, vsel constants and decode bundle.
// ST_ERR exists only with DATAPATH_CTRL_ILLEGAL_TRAP_EN defined.
package datapath_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_DECODE,
    ST_GETA,
    ST_GETB,
    ST_EXEC,
    ST_CMPX,
    ST_WREG,
    ST_WIMM
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
    ,
    ST_ERR
`endif
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef enum logic [2:0] {
    CLS_ILL,
    CLS_MOVI,
    CLS_MOVR,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN
  } cls_t;

  typedef struct packed {
    cls_t        cls;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [1:0]  aluop;
    logic [15:0] sximm8;
  } dec_t;

endpackage

// File: rtl/datapath_ctrl_decode.sv
// datapath_ctrl_decode: combinational IR -> instruction class and fields.
// Illegal-instruction trapping is handled by the FSM, not here.
module datapath_ctrl_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc = ir[15:13];
  assign op  = ir[12:11];

  always_comb begin
    dec        = '0;
    dec.cls    = CLS_ILL;
    dec.rn     = ir[10:8];
    dec.rd     = ir[7:5];
    dec.rm     = ir[2:0];
    dec.sh     = ir[4:3];
    dec.sximm8 = {{8{ir[7]}}, ir[7:0]};
    dec.aluop  = (opc == OPC_ALU) ? op : OP_ADD;
    unique case (1'b1)
      ({opc, op} == {OPC_MOV, OP_MOVI}): dec.cls = CLS_MOVI;
      ({opc, op} == {OPC_MOV, OP_MOVR}): dec.cls = CLS_MOVR;
      ({opc, op} == {OPC_ALU, OP_ADD}):  dec.cls = CLS_ADD;
      ({opc, op} == {OPC_ALU, OP_CMP}):  dec.cls = CLS_CMP;
      ({opc, op} == {OPC_ALU, OP_AND}):  dec.cls = CLS_AND;
      ({opc, op} == {OPC_ALU, OP_MVN}):  dec.cls = CLS_MVN;
      default:                           dec.cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: IR latch plus Moore FSM sequencing the Lab5 datapath.
// Define DATAPATH_CTRL_ILLEGAL_TRAP_EN to trap illegal codes in ST_ERR.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] in,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  aluop,
  output logic [15:0] sximm8,
  output logic        err
);

  logic [15:0] ir;
  state_t      state;
  state_t      state_n;
  dec_t        dec;

  datapath_ctrl_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (load) begin
      ir <= in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_WAIT: begin
        if (s) state_n = ST_DECODE;
      end
      ST_DECODE: begin
        case (dec.cls)
          CLS_MOVI: state_n = ST_WIMM;
          CLS_MOVR,
          CLS_MVN:  state_n = ST_GETB;
          CLS_ADD,
          CLS_CMP,
          CLS_AND:  state_n = ST_GETA;
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
          default:  state_n = ST_ERR;
`else
          default:  state_n = ST_WAIT;
`endif
        endcase
      end
      ST_GETA: state_n = ST_GETB;
      ST_GETB: begin
        state_n = (dec.cls == CLS_CMP) ? ST_CMPX : ST_EXEC;
      end
      ST_EXEC: state_n = ST_WREG;
      ST_CMPX,
      ST_WREG,
      ST_WIMM: state_n = ST_WAIT;
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
      ST_ERR:  state_n = ST_ERR;
`endif
      default: state_n = ST_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    shift    = 2'b00;
    aluop    = dec.aluop;
    sximm8   = dec.sximm8;
    case (state)
      ST_WAIT: w = 1'b1;
      ST_GETA: begin
        readnum = dec.rn;
        loada   = 1'b1;
      end
      ST_GETB: begin
        readnum = dec.rm;
        loadb   = 1'b1;
        shift   = dec.sh;
      end
      ST_EXEC: begin
        loadc = 1'b1;
        shift = dec.sh;
        // MOV-reg and MVN pass B through the ALU against a zero A
        asel  = (dec.cls == CLS_MOVR) || (dec.cls == CLS_MVN);
      end
      ST_CMPX: loads = 1'b1;
      ST_WREG: begin
        writenum = dec.rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      ST_WIMM: begin
        writenum = dec.rn;
        vsel     = VSEL_IMM;
        write    = 1'b1;
      end
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
      ST_ERR:  err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: scoreboard bench for datapath_ctrl.
// Honours DATAPATH_CTRL_ILLEGAL_TRAP_EN for the illegal-code case.
module tb_datapath_ctrl;

  localparam bit O = 1'b0;
  localparam bit I = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in = '0;
  logic        s = 1'b0;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  aluop;
  logic [15:0] sximm8;
  logic        err;

  datapath_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .in       (in),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .aluop    (aluop),
    .sximm8   (sximm8),
    .err      (err)
  );

  always #5 clk = ~clk;

  logic [36:0] obs;
  assign obs = {w, err, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, shift, aluop,
                readnum, writenum, sximm8};

  logic [36:0] sb[$];
  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [36:0] got,
                     input logic [36:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [36:0] e;
    if (sb.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: got output expected empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, obs, e);
    end
  endtask

  function automatic logic [36:0] rec(
    input logic [15:0] ir,
    input logic w_, err_, wr, la, lb, lc, ls, as,
    input logic [1:0] vs, sh,
    input logic [2:0] rdn, wrn);
    logic [1:0]  ao;
    logic [15:0] sx;
    ao = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
    sx = {{8{ir[7]}}, ir[7:0]};
    return {w_, err_, wr, la, lb, lc, ls, as, 1'b0,
            vs, sh, ao, rdn, wrn, sx};
  endfunction

  task automatic push_instr(input logic [15:0] ir);
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;
    logic       trap;
    rn = ir[10:8];
    rd = ir[7:5];
    rm = ir[2:0];
    sh = ir[4:3];
    trap = 1'b0;
    sb.push_back(rec(ir, O,O,O,O,O,O,O,O, 2'b00, 2'b00, 3'd0, 3'd0));
    case (ir[15:11])
      5'b11010: begin
        sb.push_back(rec(ir, O,O,I,O,O,O,O,O, 2'b10, 2'b00, 3'd0, rn));
      end
      5'b11000, 5'b10111: begin
        sb.push_back(rec(ir, O,O,O,O,I,O,O,O, 2'b00, sh, rm, 3'd0));
        sb.push_back(rec(ir, O,O,O,O,O,I,O,I, 2'b00, sh, 3'd0, 3'd0));
        sb.push_back(rec(ir, O,O,I,O,O,O,O,O, 2'b00, 2'b00, 3'd0, rd));
      end
      5'b10100, 5'b10110: begin
        sb.push_back(rec(ir, O,O,O,I,O,O,O,O, 2'b00, 2'b00, rn, 3'd0));
        sb.push_back(rec(ir, O,O,O,O,I,O,O,O, 2'b00, sh, rm, 3'd0));
        sb.push_back(rec(ir, O,O,O,O,O,I,O,O, 2'b00, sh, 3'd0, 3'd0));
        sb.push_back(rec(ir, O,O,I,O,O,O,O,O, 2'b00, 2'b00, 3'd0, rd));
      end
      5'b10101: begin
        sb.push_back(rec(ir, O,O,O,I,O,O,O,O, 2'b00, 2'b00, rn, 3'd0));
        sb.push_back(rec(ir, O,O,O,O,I,O,O,O, 2'b00, sh, rm, 3'd0));
        sb.push_back(rec(ir, O,O,O,O,O,O,I,O, 2'b00, 2'b00, 3'd0, 3'd0));
      end
      default: begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
        trap = 1'b1;
        for (int k = 0; k < 3; k++) begin
          sb.push_back(rec(ir, O,I,O,O,O,O,O,O, 2'b00, 2'b00, 3'd0, 3'd0));
        end
`endif
      end
    endcase
    if (!trap) begin
      sb.push_back(rec(ir, I,O,O,O,O,O,O,O, 2'b00, 2'b00, 3'd0, 3'd0));
    end
  endtask

  task automatic load_ir(input logic [15:0] ir);
    @(negedge clk);
    in = ir;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input string tag, input logic [15:0] ir);
    load_ir(ir);
    chk({tag, "_idle"}, obs,
        rec(ir, I,O,O,O,O,O,O,O, 2'b00, 2'b00, 3'd0, 3'd0));
    push_instr(ir);
    s = 1'b1;
    @(posedge clk);
    #1;
    s = 1'b0;
    pop_chk(tag);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      pop_chk(tag);
    end
  endtask

  initial begin
    int n;
    logic [36:0] rst_rec;
    rst_rec = rec(16'h0000, I,O,O,O,O,O,O,O, 2'b00, 2'b00, 3'd0, 3'd0);
    #12;
    chk("reset", obs, rst_rec);
    @(negedge clk);
    rst_n = 1'b1;

    run("movi", 16'hD107);
    run("movi_neg", 16'hD180);
    run("add", 16'hA140);
    run("cmp", 16'hA900);
    run("movr", 16'hC048);
    run("and", 16'hB162);
    run("mvn", 16'hB885);

    load_ir(16'hD305);
    push_instr(16'hD305);
    push_instr(16'hD305);
    s = 1'b1;
    n = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      pop_chk("b2b");
      if (n == 3) s = 1'b0;
      n++;
    end

    load_ir(16'hA140);
    sb.push_back(rec(16'hA140, O,O,O,O,O,O,O,O, 2'b00, 2'b00, 3'd0, 3'd0));
    sb.push_back(rec(16'hA140, O,O,O,I,O,O,O,O, 2'b00, 2'b00, 3'd1, 3'd0));
    s = 1'b1;
    @(posedge clk);
    #1;
    s = 1'b0;
    pop_chk("mid_dec");
    @(posedge clk);
    #1;
    pop_chk("mid_geta");
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst", obs, rst_rec);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst", obs, rst_rec);

    run("ill", 16'hE000);
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ill_rst", obs,
        rec(16'h0000, I,O,O,O,O,O,O,O, 2'b00, 2'b00, 3'd0, 3'd0));
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
